// File: rtl/gb_pkg.sv
// Shared Game Boy definitions: OAM map, DMA register
// address and the OAM DMA engine state encoding.
package gb_pkg;

  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_BYTES    = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  ECHO_BASE_HI = 8'hE0;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from
// page {XX,00} into OAM, one byte per M-cycle.
module oam_dma
  import gb_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mmio_a,
  input  logic [7:0]  mmio_din,
  input  logic        mmio_wr,
  output logic [7:0]  mmio_dout,
  output logic [15:0] src_a,
  output logic        src_rd,
  input  logic [7:0]  src_dout,
  output logic [15:0] oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_wr,
  output logic        dma_active
);

  localparam int PW = $clog2(CYCLES_PER_BYTE);
  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0]    IDX_LAST = 8'(OAM_BYTES - 1);

  dma_state_t    state;
  logic [7:0]    dma_reg;
  logic [7:0]    idx;
  logic [PW-1:0] ph;
  logic [7:0]    page;
  logic          trig;

  assign trig = mmio_wr && (mmio_a == DMA_REG_ADDR);

  // Echo RAM pages E0..FF fold back onto work RAM C0..DF.
  assign page = (dma_reg < ECHO_BASE_HI)
              ? dma_reg
              : dma_reg - 8'h20;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= DMA_IDLE;
      dma_reg <= '0;
      idx     <= '0;
      ph      <= '0;
    end else if (trig) begin
      dma_reg <= mmio_din;
      idx     <= '0;
      ph      <= '0;
      state   <= DMA_START;
    end else begin
      unique case (state)
        DMA_IDLE: begin
          ph <= '0;
        end
        DMA_START: begin
          if (ph == PH_LAST) begin
            ph    <= '0;
            state <= DMA_XFER;
          end else begin
            ph <= ph + PW'(1);
          end
        end
        DMA_XFER: begin
          if (ph == PH_LAST) begin
            ph <= '0;
            if (idx == IDX_LAST) state <= DMA_IDLE;
            else                 idx   <= idx + 8'd1;
          end else begin
            ph <= ph + PW'(1);
          end
        end
        default: state <= DMA_IDLE;
      endcase
    end
  end

  assign dma_active = (state != DMA_IDLE);
  assign src_rd     = (state == DMA_XFER) && (ph == '0);
  assign oam_wr     = (state == DMA_XFER) && (ph == PW'(1));

  assign src_a   = src_rd ? {page, idx} : '0;
  assign oam_a   = oam_wr ? OAM_BASE + {8'h00, idx} : '0;
  assign oam_din = oam_wr ? src_dout : '0;

  assign mmio_dout = (mmio_a == DMA_REG_ADDR && !mmio_wr)
                   ? dma_reg : '0;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: directed triggers, retrigger,
// reset abort, foreign-register writes and a 2-clock/byte build.
module tb_oam_dma;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] mmio_a = 0;
  logic [7:0]  mmio_din = 0;
  logic        mmio_wr = 0;
  logic [7:0]  mmio_dout;
  logic [15:0] src_a;
  logic        src_rd;
  logic [7:0]  src_dout = 0;
  logic [15:0] oam_a;
  logic [7:0]  oam_din;
  logic        oam_wr;
  logic        dma_active;

  logic [15:0] mmio_a2 = 0;
  logic [7:0]  mmio_din2 = 0;
  logic        mmio_wr2 = 0;
  logic [7:0]  mmio_dout2;
  logic [15:0] src_a2;
  logic        src_rd2;
  logic [7:0]  src_dout2 = 0;
  logic [15:0] oam_a2;
  logic [7:0]  oam_din2;
  logic        oam_wr2;
  logic        dma_active2;

  oam_dma #(.CYCLES_PER_BYTE(4)) dut (
    .clk(clk), .rst(rst),
    .mmio_a(mmio_a), .mmio_din(mmio_din), .mmio_wr(mmio_wr),
    .mmio_dout(mmio_dout),
    .src_a(src_a), .src_rd(src_rd), .src_dout(src_dout),
    .oam_a(oam_a), .oam_din(oam_din), .oam_wr(oam_wr),
    .dma_active(dma_active)
  );

  oam_dma #(.CYCLES_PER_BYTE(2)) dut2 (
    .clk(clk), .rst(rst),
    .mmio_a(mmio_a2), .mmio_din(mmio_din2), .mmio_wr(mmio_wr2),
    .mmio_dout(mmio_dout2),
    .src_a(src_a2), .src_rd(src_rd2), .src_dout(src_dout2),
    .oam_a(oam_a2), .oam_din(oam_din2), .oam_wr(oam_wr2),
    .dma_active(dma_active2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int first_k = -1;
  logic [15:0] first_a = 0;
  int wr_count = 0;
  int last_cyc = 0;
  int exp_page = 256;
  int drops = 0;

  // Source memory: page C1 holds i^5A, other pages differ.
  function automatic logic [7:0] mem(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] r);
    logic [7:0] p;
    p = r;
    if (r >= 8'hE0) p = r - 8'h20;
    return p;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (src_rd) src_dout <= mem(src_a);
    if (src_rd2) src_dout2 <= mem(src_a2);
  end

  always @(negedge clk) begin
    exp_t e;
    if (dma_active) begin
      busy_cnt++;
      if (src_rd && first_k < 0) begin
        first_k = busy_cnt;
        first_a = src_a;
      end
    end
    if (src_rd) begin
      if (exp_page > 255) chk("src_unexpected", {16'h0, src_a}, 0);
      else chk("src_page", {24'h0, src_a[15:8]}, exp_page);
    end
    if (oam_wr) begin
      if (sb.size() == 0) begin
        chk("oam_unexpected", {16'h0, oam_a}, 0);
      end else begin
        e = sb.pop_front();
        chk("oam_a", {16'h0, oam_a}, {16'h0, e.a});
        chk("oam_din", {24'h0, oam_din}, {24'h0, e.d});
        if (wr_count > 0) chk("oam_gap", cyc - last_cyc, 4);
        last_cyc = cyc;
        wr_count++;
      end
    end
  end

  task automatic write(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] p;
    @(posedge clk); #1;
    mmio_a = a; mmio_din = d; mmio_wr = 1;
    @(posedge clk); #1;
    mmio_wr = 0; mmio_a = 0;
    if (a == 16'hFF46) begin
      p = fold(d);
      exp_page = int'(p);
      sb.delete();
      for (int i = 0; i < 160; i++)
        sb.push_back('{16'hFE00 + 16'(i), mem({p, 8'(i)})});
      busy_cnt = 0;
      first_k = -1;
      wr_count = 0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (dma_active && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (dma_active) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_wr(input int target);
    int n;
    n = 0;
    while (wr_count < target && n < 3000) begin
      @(negedge clk);
      if (!dma_active) drops++;
      n++;
    end
    if (wr_count < target) chk("wr_timeout", wr_count, target);
  endtask

  initial begin
    int busy2, wr2, gap_bad, last2, n;
    logic [15:0] last_a2;
    logic        data_bad;

    repeat (3) @(posedge clk);
    #1 rst = 0;
    mmio_a = 16'hFF46;
    @(negedge clk);
    chk("rst_active", dma_active, 0);
    chk("rst_src_rd", src_rd, 0);
    chk("rst_oam_wr", oam_wr, 0);
    chk("rst_src_a", {16'h0, src_a}, 0);
    chk("rst_oam_a", {16'h0, oam_a}, 0);
    chk("rst_oam_din", {24'h0, oam_din}, 0);
    chk("rst_reg", {24'h0, mmio_dout}, 0);

    write(16'hFF46, 8'hC1);
    wait_idle();
    chk("c1_busy", busy_cnt, 644);
    chk("c1_first_k", first_k, 5);
    chk("c1_first_a", {16'h0, first_a}, 32'hC100);
    chk("c1_count", wr_count, 160);

    write(16'hFF46, 8'hE2);
    repeat (20) @(posedge clk);
    write(16'hFF47, 8'hAB);
    #1 mmio_a = 16'hFF40;
    @(negedge clk);
    chk("ff40_read", {24'h0, mmio_dout}, 0);
    @(posedge clk); #1 mmio_a = 16'hFF46;
    @(negedge clk);
    chk("e2_read", {24'h0, mmio_dout}, 32'hE2);
    @(posedge clk); #1 mmio_a = 0;
    wait_idle();
    chk("e2_busy", busy_cnt, 644);
    chk("e2_count", wr_count, 160);
    chk("e2_first_a", {16'h0, first_a}, 32'hC200);

    write(16'hFF46, 8'h80);
    drops = 0;
    wait_wr(50);
    write(16'hFF46, 8'hC0);
    chk("retrig_no_drop", drops, 0);
    wait_idle();
    chk("retrig_busy", busy_cnt, 644);
    chk("retrig_count", wr_count, 160);
    chk("retrig_first_a", {16'h0, first_a}, 32'hC000);

    write(16'hFF46, 8'hC3);
    wait_wr(100);
    @(posedge clk); #1;
    rst = 1;
    exp_page = 256;
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    mmio_a = 16'hFF46;
    @(negedge clk);
    chk("abort_active", dma_active, 0);
    chk("abort_reg", {24'h0, mmio_dout}, 0);
    repeat (40) @(posedge clk);
    chk("abort_count", wr_count, 100);
    #1 mmio_a = 0;

    @(posedge clk); #1;
    mmio_a2 = 16'hFF46; mmio_din2 = 8'hC1; mmio_wr2 = 1;
    @(posedge clk); #1;
    mmio_wr2 = 0; mmio_a2 = 0;
    busy2 = 0; wr2 = 0; gap_bad = 0; last2 = 0; n = 0;
    last_a2 = 0; data_bad = 0;
    @(negedge clk);
    while (dma_active2 && n < 2000) begin
      busy2++;
      if (oam_wr2) begin
        if (wr2 > 0 && n - last2 != 2) gap_bad++;
        if (oam_din2 !== (8'(wr2) ^ 8'h5A)) data_bad = 1;
        last2 = n;
        last_a2 = oam_a2;
        wr2++;
      end
      @(negedge clk);
      n++;
    end
    chk("cpb2_busy", busy2, 322);
    chk("cpb2_count", wr2, 160);
    chk("cpb2_gaps", gap_bad, 0);
    chk("cpb2_data", data_bad, 0);
    chk("cpb2_last_a", {16'h0, last_a2}, 32'hFE9F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine. A CPU write to `0xFF46` copies 160 bytes from `{XX, 8'h00}` into OAM (`0xFE00`–`0xFE9F`). It sits upstream of the PPU: it owns the OAM write port while active and shares the OAM RAM with the PPU's mode-2 OAM search. It owns the `DMA` register that the PPU register file does not implement.

## Interface
- `CYCLES_PER_BYTE`, default 4: clocks per transferred byte (one M-cycle); legal range ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `mmio_a` in 16: CPU register address.
- `mmio_din` in 8: CPU write data.
- `mmio_wr` in 1: CPU write strobe, one clock per write.
- `mmio_dout` out 8: `DMA` register when `mmio_a==16'hFF46` and `!mmio_wr`, else 0 (ORed onto the CPU read bus).
- `src_a` out 16: source-memory address.
- `src_rd` out 1: source read strobe.
- `src_dout` in 8: source read data, valid exactly 1 clock after `src_rd`.
- `oam_a` out 16: OAM write address.
- `oam_din` out 8: OAM write data.
- `oam_wr` out 1: OAM write strobe.
- `dma_active` out 1: high while the engine is busy. The CPU bus arbiter blocks CPU access to everything except HRAM while this is high; the OAM mux gives the port to `oam_dma`.

## Operation
- States: `IDLE`, `START`, `XFER`.
- Registers: `dma_reg[7:0]` (reset 0), byte index `idx[7:0]` (0..159), phase counter `ph` (0..`CYCLES_PER_BYTE`-1).
- Trigger: `mmio_wr && mmio_a==16'hFF46` in any state.
  - `dma_reg <= mmio_din`; `idx <= 0`; `ph <= 0`; `state <= START`.
  - A trigger while busy restarts the transfer from byte 0 with the new page. The old transfer is abandoned with no further writes.
- `START`: one M-cycle of setup delay. The engine waits `CYCLES_PER_BYTE` clocks, then goes to `XFER` with `ph=0`.
- `XFER`, per byte `idx`:
  - `ph==0`: `src_rd=1`, `src_a={page, idx}`.
  - `ph==1`: `oam_wr=1`, `oam_a=16'hFE00+idx`, `oam_din=src_dout`.
  - Other phases: idle.
  - At `ph==CYCLES_PER_BYTE-1`: `ph<=0` and `idx<=idx+1`. If `idx==159` instead, `state<=IDLE`.
- Page mapping: `page = dma_reg` if `dma_reg < 8'hE0`, else `dma_reg - 8'h20` (echo RAM folds to `0xC0xx`–`0xDFxx`). Subtract in 8 bits.
- `dma_active = (state != IDLE)`.
- Strobe outputs are combinational from the state registers. When not strobing, `src_a`, `oam_a` and `oam_din` drive 0.
- Writes to `0xFF46` are always accepted, even while active, because the CPU can still reach the register from its HRAM loop.
- `mmio_dout` reads return `dma_reg` unchanged (the written value, not the folded page).

## Timing
- Reset values:
  - `dma_reg=0`, `state=IDLE`.
  - All outputs 0: `mmio_dout` is 0 unless `mmio_a==FF46` is read; `src_*`, `oam_*` and `dma_active` are 0.
- A trigger write at edge T gives `dma_active=1` from the clock after T.
- The first `src_rd` is at T+1+`CYCLES_PER_BYTE`. The first `oam_wr` follows one clock later.
- Total busy time is `CYCLES_PER_BYTE*161` clocks (644 at the default). `dma_active` falls on the clock after the last byte's final phase.
- Exactly 160 `oam_wr` pulses per completed transfer, at addresses strictly `0xFE00`..`0xFE9F` in order, spaced `CYCLES_PER_BYTE` apart.
- Retrigger on the same edge as a byte's `ph==0`: the trigger wins. That byte's `oam_wr` is not issued.
- `rst` mid-transfer: the engine goes to `IDLE` on the next edge with no further strobes, and `dma_reg` clears.
- Writes to other addresses (including `0xFF45` and `0xFF47`) have no effect.

## Structure
- Shared package `gb_pkg`: `OAM_BASE=16'hFE00`, `OAM_BYTES=160`, `DMA_REG_ADDR=16'hFF46`, `ECHO_BASE_HI=8'hE0`, and `typedef enum {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t`.
- Single module. No sub-module: the `ph`/`idx` counters are simple enough to live inline.
- Expected RTL size is about 150 lines.

## Test plan
- Write `0xC1` to `FF46` with a source model holding `mem[C100+i]=i^8'h5A`:
  - 160 `oam_wr` at `FE00+i` with data `i^5A`;
  - `dma_active` high for exactly 644 clocks;
  - the first `src_a` is `16'hC100` at T+5.
- Write `0xE2`: all `src_a` fall in `C200`..`C29F`, and reading `FF46` returns `8'hE2`.
- Write `0x80`, then at byte 50 write `0xC0`:
  - no more writes are sourced from `0x80xx`;
  - the transfer restarts with `FE00` sourced from `C000`;
  - `dma_active` never drops;
  - the total busy time after the second write is 644 clocks.
- Assert `rst` at byte 100: no strobes follow, `dma_active=0` and `dma_reg=0` on the next clock, and a FF46 read returns 0.
- Run with `CYCLES_PER_BYTE=2`: busy time is 322 clocks and `oam_wr` pulses are 2 clocks apart.
- Write `FF47` and read `FF40` while a transfer is active: the transfer is unaffected, `mmio_dout=0`, and no trigger occurs.
